// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Owns the program counter, fetches
// words from instruction memory over a req/ack handshake and queues the
// returned {pc, inst} pairs in a small FIFO whose head feeds the IF/ID register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] HALT_INST = 32'h0000_0073
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        valid_if,
   output logic [31:0] PC_if,
   output logic [31:0] Inst_if,
   output logic        halt_if
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} fetch_state_t;

   fetch_state_t     state, state_next;
   logic [31:0]      fetch_pc, fetch_pc_next;
   logic [31:0]      drop_addr;
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      inst_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count, count_next;
   logic             push, pop, space;

   // An ack only becomes a FIFO entry when it answers a live request and no
   // redirect is squashing it; the head leaves when IF/ID takes it.
   assign push  = (state == REQ) && imem_ack && !redirect_valid;
   assign pop   = valid_if && !stall && !redirect_valid;
   assign space = (count_next < CNT_W'(DEPTH));

   // A dropped request keeps presenting its original address until its ack,
   // even though fetch_pc already points at the redirect target.
   assign imem_req  = (state == REQ) || (state == DROP);
   assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;

   assign valid_if = (count != '0);
   assign PC_if    = valid_if ? pc_q[rd_ptr]   : 32'd0;
   assign Inst_if  = valid_if ? inst_q[rd_ptr] : 32'd0;
   assign halt_if  = valid_if && (inst_q[rd_ptr] == HALT_INST);

   // Occupancy after this edge; a redirect empties the FIFO outright.
   always_comb begin
      count_next = count;
      if (redirect_valid)
         count_next = '0;
      else if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (pop && !push)
         count_next = count - CNT_W'(1);
   end

   // Next fetch address and fetch FSM transitions; redirect overrides everything.
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      if (push)
         fetch_pc_next = fetch_pc + 32'd4;
      if (redirect_valid)
         fetch_pc_next = {redirect_pc[31:2], 2'b00};
      case (state)
         IDLE: begin
            if (redirect_valid || space)
               state_next = REQ;
         end
         REQ: begin
            if (redirect_valid)
               state_next = imem_ack ? REQ : DROP;
            else if (imem_ack) begin
               if (imem_rdata == HALT_INST)
                  state_next = HALT;
               else if (space)
                  state_next = REQ;
               else
                  state_next = IDLE;
            end
         end
         DROP: begin
            if (imem_ack)
               state_next = REQ;
         end
         HALT: begin
            if (redirect_valid)
               state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   // Control state: FSM, program counter, dropped address and FIFO pointers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         drop_addr <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         count    <= count_next;
         if ((state == REQ) && redirect_valid && !imem_ack)
            drop_addr <= fetch_pc;
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // FIFO storage needs no reset: entries are only visible while count is non-zero.
   always_ff @(posedge CLK) begin
      if (push) begin
         pc_q[wr_ptr]   <= fetch_pc;
         inst_q[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: drives if_fetch_unit with a latency-randomised instruction
// memory plus stall/redirect stimulus, and checks the delivered instruction
// stream against an in-order program-counter model.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          DEPTH     = 2;
   localparam logic [31:0] HALT_INST = 32'h0000_0073;

   logic        CLK;
   logic        RST;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid_if;
   logic [31:0] PC_if;
   logic [31:0] Inst_if;
   logic        halt_if;

   int cmp_count  = 0;
   int fail_count = 0;

   // memory model state
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_wait;
   int          max_wait;
   logic        hold_en;
   logic [31:0] hold_addr;
   int          hold_cycles;
   logic        halt_en;
   logic [31:0] halt_addr;

   // stream model state
   logic [31:0] exp_pc;
   logic        halted_exp;
   int          idle_run;
   logic        saw_halt_if;
   logic        saw_past_halt;

   if_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .DEPTH     (DEPTH),
      .HALT_INST (HALT_INST)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .valid_if       (valid_if),
      .PC_if          (PC_if),
      .Inst_if        (Inst_if),
      .halt_if        (halt_if)
   );

   // free-running clock, period 10
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // hard stop in case a wait escapes its bound
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // memory contents: a fixed pattern per address, never equal to HALT_INST
   // unless the halt word is planted at halt_addr
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (halt_en && a == halt_addr)
         return HALT_INST;
      return {a[23:0] ^ 24'h5A3C96, 8'hEF};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      cmp_count++;
      if (obs !== expv) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_req",   {31'd0, imem_req}, 32'd0);
      checkOutput("rst_addr",  imem_addr,         RESET_PC);
      checkOutput("rst_valid", {31'd0, valid_if}, 32'd0);
      checkOutput("rst_pc",    PC_if,             32'd0);
      checkOutput("rst_inst",  Inst_if,           32'd0);
      checkOutput("rst_halt",  {31'd0, halt_if},  32'd0);
   endtask

   task automatic resetModel();
      mem_busy   = 1'b0;
      mem_wait   = 0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      exp_pc     = RESET_PC;
      halted_exp = 1'b0;
      idle_run   = 0;
   endtask

   // One cycle, entered at a falling edge: the memory answers, stall/redirect
   // are driven, the head is checked against the model, then the model advances.
   task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc);
      logic        consume;
      logic [31:0] exp_inst;
      if (imem_req) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            if (hold_en && imem_addr == hold_addr) begin
               mem_wait = hold_cycles;
               hold_en  = 1'b0;
            end else
               mem_wait = $urandom_range(0, max_wait);
            checkOutput("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (halt_en && imem_addr == halt_addr + 32'd4)
               saw_past_halt = 1'b1;
         end else
            checkOutput("addr_hold", imem_addr, mem_addr);
         if (mem_wait == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = memWord(mem_addr);
            mem_busy   = 1'b0;
         end else begin
            mem_wait--;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
         end
      end else begin
         if (mem_busy)
            checkOutput("req_held", {31'd0, imem_req}, 32'd1);
         mem_busy   = 1'b0;
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
      end
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      if (dut.push)
         checkOutput("push_room", {31'd0, dut.count < DEPTH}, 32'd1);
      if (halted_exp)
         checkOutput("valid_after_halt", {31'd0, valid_if}, 32'd0);
      if (valid_if) begin
         exp_inst = memWord(exp_pc);
         checkOutput("head_pc",   PC_if,   exp_pc);
         checkOutput("head_inst", Inst_if, exp_inst);
         checkOutput("head_halt", {31'd0, halt_if}, {31'd0, exp_inst == HALT_INST});
         if (halt_if)
            saw_halt_if = 1'b1;
      end else begin
         checkOutput("empty_pc",   PC_if,             32'd0);
         checkOutput("empty_inst", Inst_if,           32'd0);
         checkOutput("empty_halt", {31'd0, halt_if},  32'd0);
      end
      consume = valid_if && !st && !rv;
      if (consume) begin
         if (memWord(exp_pc) == HALT_INST)
            halted_exp = 1'b1;
         exp_pc = exp_pc + 32'd4;
      end
      if (rv) begin
         exp_pc     = {rpc[31:2], 2'b00};
         halted_exp = 1'b0;
      end
      if (consume || rv || halted_exp)
         idle_run = 0;
      else if (!st)
         idle_run++;
      if (idle_run > 12) begin
         checkOutput("progress", idle_run, 32'd0);
         idle_run = 0;
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      int n;
      RST            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      max_wait       = 0;
      hold_en        = 1'b0;
      hold_addr      = 32'd0;
      hold_cycles    = 0;
      halt_en        = 1'b0;
      halt_addr      = 32'd0;
      saw_halt_if    = 1'b0;
      saw_past_halt  = 1'b0;
      mem_addr       = 32'd0;
      resetModel();

      // reset values and first request
      #2;
      checkResetOutputs();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      checkOutput("pre_first_req", {31'd0, imem_req}, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("first_req",  {31'd0, imem_req}, 32'd1);
      checkOutput("first_addr", imem_addr,         RESET_PC);

      // always-ack streaming: one instruction per cycle
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("latency_valid", {31'd0, valid_if}, 32'd1);
      for (int i = 1; i <= 20; i++) begin
         checkOutput("seq_addr", imem_addr, RESET_PC + 32'(i * 4));
         applyStimulus(1'b0, 1'b0, 32'd0);
         checkOutput("tput_valid", {31'd0, valid_if}, 32'd1);
      end

      // stall for 3 cycles: FIFO fills and requests stop
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkOutput("stall_req_off", {31'd0, imem_req}, 32'd0);
      end
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, 1'b0, 32'd0);

      // redirect to 0x100 while the 0x20 request waits for its ack
      hold_en     = 1'b1;
      hold_addr   = 32'h20;
      hold_cycles = 2;
      applyStimulus(1'b0, 1'b1, 32'h0);
      n = 0;
      while (!(imem_req && imem_addr == 32'h20) && n < 40) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         n++;
      end
      checkOutput("reach_0x20", {31'd0, imem_req && imem_addr == 32'h20}, 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h100);
      checkOutput("flush_valid", {31'd0, valid_if}, 32'd0);
      checkOutput("drop_req",    {31'd0, imem_req}, 32'd1);
      checkOutput("drop_addr",   imem_addr,         32'h20);
      n = 0;
      while (!(imem_req && imem_addr != 32'h20) && n < 10) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         n++;
      end
      checkOutput("redirect_addr", imem_addr, 32'h100);
      n = 0;
      while (!valid_if && n < 10) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         n++;
      end
      checkOutput("redirect_head", PC_if, 32'h100);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 32'd0);

      // redirect coinciding with an ack and a would-be consume
      checkOutput("pre_same_valid", {31'd0, valid_if}, 32'd1);
      checkOutput("pre_same_req",   {31'd0, imem_req}, 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h200);
      checkOutput("same_flush", {31'd0, valid_if}, 32'd0);
      checkOutput("same_req",   {31'd0, imem_req}, 32'd1);
      checkOutput("same_addr",  imem_addr,         32'h200);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 32'd0);

      // halt word at 0x10 stops fetching; redirect to 0x40 resumes
      halt_en       = 1'b1;
      halt_addr     = 32'h10;
      saw_halt_if   = 1'b0;
      saw_past_halt = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("halt_seen",      {31'd0, saw_halt_if},   32'd1);
      checkOutput("no_fetch_0x14",  {31'd0, saw_past_halt}, 32'd0);
      checkOutput("halt_req_off",   {31'd0, imem_req},      32'd0);
      applyStimulus(1'b0, 1'b1, 32'h40);
      n = 0;
      while (!valid_if && n < 10) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         n++;
      end
      checkOutput("resume_head", PC_if, 32'h40);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 32'd0);

      // asynchronous reset in the middle of an outstanding request
      max_wait = 4;
      n = 0;
      while (!imem_req && n < 10) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         n++;
      end
      checkOutput("mid_req", {31'd0, imem_req}, 32'd1);
      imem_ack = 1'b0;
      #2;
      RST = 1'b0;
      #1;
      checkResetOutputs();
      halt_en = 1'b0;
      resetModel();
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      checkOutput("rel_req_low", {31'd0, imem_req}, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("restart_req",  {31'd0, imem_req}, 32'd1);
      checkOutput("restart_addr", imem_addr,         RESET_PC);

      // randomised stall/redirect traffic with variable memory latency
      max_wait = 3;
      for (int i = 0; i < 800; i++) begin
         logic        st, rv;
         logic [31:0] rpc;
         st  = ($urandom_range(0, 3) == 0);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = $urandom & 32'h0000_0FFF;
         applyStimulus(st, rv, rpc);
      end
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 1'b0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
